xsim_run_ctrl: RTL and testbench
================================

# xsim_run_ctrl

Run controller for the simulation top level, single clock domain. It sequences DUT reset release for the main and derived resets, counts simulation cycles, and turns a host finish request (polled over DPI) into an orderly shutdown. Shutdown drains to DUT idle with a bounded timeout, then issues a single finish strobe. It replaces the ad-hoc reset/finish logic around `mkXsimTop`.

## Interface
**Parameters**
- `RESET_CYCLES`, 20: main cycles `rst_n_out` is held low after `RST` deasserts.
- `DERIVED_RESET_CYCLES`, 20: main cycles before `derived_rst_release` rises. Independent of `RESET_CYCLES`.
- `DRAIN_TIMEOUT`, 1024: maximum DRAIN cycles. 0 means no timeout.
- `CNT_W`, 32: width of the cycle and drain counters.

**Ports**
- `CLK` in 1: main clock. All state updates on rising edge.
- `RST` in 1: reset. Asynchronous assert, active-high.
- `finish_req` in 1: level request from the DPI finish poll.
- `dut_idle` in 1: DUT quiescent indicator.
- `rst_n_out` out 1: active-low reset to the DUT main domain.
- `derived_rst_release` out 1: level. The derived domain synchronizes it externally.
- `cycle_count` out CNT_W: cycles since `RST` deassert. Saturating.
- `state` out 3: current FSM state encoding.
- `finish_now` out 1: one-cycle strobe. The top calls `$finish` on it.
- `timed_out` out 1: sticky. Set when the drain ended by timeout.

## Operation
- **Reset values** while `RST`=1: state=RESET_HOLD, `cycle_count`=0, `rst_n_out`=0, `derived_rst_release`=0, `finish_now`=0, `timed_out`=0, `req_q`=0, `pending`=0, drain counter=0.
- **`cycle_count`**: +1 every edge, saturates at all-ones. No wrap.
- **`req_q`**: `finish_req` registered once. All decisions use `req_q`, never raw `finish_req`.
- **RESET_HOLD**
  - At an edge where pre-edge `cycle_count`==`RESET_CYCLES`: set `rst_n_out`=1 and go to RUN.
  - `derived_rst_release` is set independently when pre-edge `cycle_count`==`DERIVED_RESET_CYCLES`, in any state. Once set it stays 1 until `RST`.
  - If `req_q`=1 in this state, set sticky `pending`.
- **RUN**: if `req_q` or `pending` is 1, go to DRAIN, clear the drain counter and clear `pending`.
- **DRAIN**, checked in this priority order each edge:
  - `dut_idle`=1 → FINISH.
  - `DRAIN_TIMEOUT`≠0 and drain counter==`DRAIN_TIMEOUT`-1 → FINISH, set `timed_out`=1.
  - otherwise drain counter +1.
  - `req_q` is ignored from DRAIN onward.
- **FINISH**: `finish_now`=1 for exactly this one cycle, then go to DONE.
- **DONE**: terminal. All outputs hold, `finish_now`=0. Only `RST` exits.
- **State encoding** (package enum): RESET_HOLD=0, RUN=1, DRAIN=2, FINISH=3, DONE=4.
- **Reset mid-operation**: `RST` asserted in any state returns all outputs to reset values asynchronously, including clearing a sticky `timed_out`. The sequence restarts from count 0 on deassert.
- **`RESET_CYCLES`=0**: `rst_n_out` rises at the first edge after deassert.

## Timing
- **Main reset release**: edges after `RST` deassert are numbered 1, 2, …. `rst_n_out` becomes 1 after edge `RESET_CYCLES`+1 (edge 21 at default).
- **Derived release**: `derived_rst_release` rises after edge `DERIVED_RESET_CYCLES`+1.
- **Finish request**: `finish_req` high before edge n gives `req_q`=1 after n. From RUN, state=DRAIN after n+1.
- **Drain with idle**: `dut_idle`=1 on DRAIN's first cycle gives `finish_now`=1 in the cycle after edge n+2. Minimum request-to-strobe latency is 3 edges.
- **Drain timeout**: with `dut_idle` held 0, FINISH is entered after exactly `DRAIN_TIMEOUT` DRAIN cycles.
- **Output registers**: all outputs are registered, no combinational input-to-output paths. `state` is the FSM register itself.

## Structure
- **Package `xsim_run_pkg`**: `run_state_t` enum (3 bits, values above) and default parameter constants.
- **Sub-module `xsim_sat_counter`**: width-parameterized, with clear and enable inputs, saturating at all-ones. Instantiate it for `cycle_count` and for the drain counter.
- **Top file**: the FSM lives in `xsim_run_ctrl`.

## Test plan
- **Default reset release**: `RST` pulse, `finish_req`=0 → `rst_n_out` rises after edge 21, `derived_rst_release` after edge 21, state=RUN, `cycle_count`=21 at that point.
- **Early request**: `DERIVED_RESET_CYCLES`=5, `finish_req`=1 from edge 3 → `derived_rst_release` after edge 6; `pending` set; RESET_HOLD→RUN at edge 21, DRAIN at edge 22; `dut_idle`=1 gives `finish_now` one cycle after edge 23, `timed_out`=0.
- **Drain by idle**: in RUN, `finish_req` pulses for 1 cycle and `dut_idle` goes 1 on the 7th DRAIN cycle → exactly one `finish_now` pulse, `timed_out`=0, state ends in DONE.
- **Drain by timeout**: `DRAIN_TIMEOUT`=4, `dut_idle` stuck 0 → DRAIN lasts 4 cycles, then FINISH; `timed_out`=1 and stays 1 in DONE.
- **Reset mid-drain**: `RST` asserted mid-drain, between clock edges → all outputs return to their reset values immediately (no clock edge needed); the release sequence repeats after deassert.
- **Saturation**: `CNT_W`=4 → `cycle_count` reaches 15 and holds; `RESET_CYCLES`=0 gives `rst_n_out` after edge 1.

Source files
------------

// File: rtl/xsim_run_pkg.sv
// xsim_run_pkg: shared FSM state type and default parameters for the run controller.
package xsim_run_pkg;
    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        RUN        = 3'd1,
        DRAIN      = 3'd2,
        FINISH     = 3'd3,
        DONE       = 3'd4
    } run_state_t;
    localparam int DEF_RESET_CYCLES         = 20;
    localparam int DEF_DERIVED_RESET_CYCLES = 20;
    localparam int DEF_DRAIN_TIMEOUT        = 1024;
    localparam int DEF_CNT_W                = 32;
endpackage

// File: rtl/xsim_sat_counter.sv
// xsim_sat_counter: up counter with sync clear and enable, saturating at all-ones.
// Ports: CLK clock, RST async active-high reset, clr sync clear (wins over en),
//        en count enable, count current value.
module xsim_sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != '1)
            count <= count + W'(1);
    end
endmodule

// File: rtl/xsim_run_ctrl.sv
// xsim_run_ctrl: sequences DUT reset release, counts cycles and turns a finish request into a drained shutdown.
// Ports: CLK clock, RST async active-high reset, finish_req host finish level, dut_idle DUT quiescent,
//        rst_n_out main DUT reset (active low), derived_rst_release derived-domain release level,
//        cycle_count saturating cycles since reset, state FSM state, finish_now one-cycle finish strobe,
//        timed_out sticky drain-timeout flag.
module xsim_run_ctrl
    import xsim_run_pkg::*;
#(
    parameter int RESET_CYCLES         = DEF_RESET_CYCLES,
    parameter int DERIVED_RESET_CYCLES = DEF_DERIVED_RESET_CYCLES,
    parameter int DRAIN_TIMEOUT        = DEF_DRAIN_TIMEOUT,
    parameter int CNT_W                = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             finish_req,
    input  logic             dut_idle,
    output logic             rst_n_out,
    output logic             derived_rst_release,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state,
    output logic             finish_now,
    output logic             timed_out
);
    // Compare in a width that holds both the counter and the int parameters, so
    // an out-of-range threshold never aliases onto a truncated count.
    localparam int XW = (CNT_W > 32) ? CNT_W : 32;
    run_state_t       st, st_d;
    logic             req_q, pending, pend_d, rst_n_d, tmo_d;
    logic             drain_clr, drain_en, rst_hit, drv_hit, to_hit;
    logic [CNT_W-1:0] drain_cnt;
    assign rst_hit = XW'(cycle_count) == XW'(RESET_CYCLES);
    assign drv_hit = XW'(cycle_count) == XW'(DERIVED_RESET_CYCLES);
    assign to_hit  = (DRAIN_TIMEOUT != 0) && (XW'(drain_cnt) == XW'(DRAIN_TIMEOUT - 1));
    assign state   = st;
    xsim_sat_counter #(.W(CNT_W)) u_cycle (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (1'b0),
        .en    (1'b1),
        .count (cycle_count)
    );
    xsim_sat_counter #(.W(CNT_W)) u_drain (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (drain_clr),
        .en    (drain_en),
        .count (drain_cnt)
    );
    always_comb begin
        st_d      = st;
        pend_d    = pending;
        rst_n_d   = rst_n_out;
        tmo_d     = timed_out;
        drain_clr = 1'b0;
        drain_en  = 1'b0;
        case (st)
            RESET_HOLD: begin
                pend_d = pending | req_q;
                if (rst_hit) begin
                    rst_n_d = 1'b1;
                    st_d    = RUN;
                end
            end
            RUN: if (req_q || pending) begin
                st_d      = DRAIN;
                drain_clr = 1'b1;
                pend_d    = 1'b0;
            end
            DRAIN: begin
                if (dut_idle)
                    st_d = FINISH;
                else if (to_hit) begin
                    st_d  = FINISH;
                    tmo_d = 1'b1;
                end else
                    drain_en = 1'b1;
            end
            FINISH: st_d = DONE;
            default: ;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st                  <= RESET_HOLD;
            req_q               <= 1'b0;
            pending             <= 1'b0;
            rst_n_out           <= 1'b0;
            derived_rst_release <= 1'b0;
            finish_now          <= 1'b0;
            timed_out           <= 1'b0;
        end else begin
            st                  <= st_d;
            req_q               <= finish_req;
            pending             <= pend_d;
            rst_n_out           <= rst_n_d;
            derived_rst_release <= derived_rst_release | drv_hit;
            // Registered strobe: high exactly while the FSM sits in FINISH.
            finish_now          <= (st_d == FINISH);
            timed_out           <= tmo_d;
        end
    end
endmodule

// File: tb/tb_xsim_run_ctrl.sv
// tb_xsim_run_ctrl: three parameterizations driven with directed and random stimulus, checked against an event-time model.
module tb_xsim_run_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        finish_req = 1'b0;
    logic        dut_idle = 1'b0;
    logic        rn[3], dr[3], fn[3], tmo[3];
    logic [2:0]  st[3];
    logic [31:0] cc_a, cc_b;
    logic [3:0]  cc_c;
    int total = 0;
    int bad = 0;
    int rc[3]  = '{20, 20, 0};
    int drc[3] = '{20, 5, 3};
    int tov[3] = '{1024, 4, 0};
    longint mx[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
    // Model: m = edges since deassert; e = edge entering DRAIN; f = edge entering FINISH (-1 = not yet).
    int m;
    int e[3], f[3];
    bit pend[3], tflag[3];
    bit fr_prev;

    always #5 CLK = ~CLK;

    xsim_run_ctrl u_a (
        .CLK(CLK), .RST(RST), .finish_req(finish_req), .dut_idle(dut_idle),
        .rst_n_out(rn[0]), .derived_rst_release(dr[0]), .cycle_count(cc_a),
        .state(st[0]), .finish_now(fn[0]), .timed_out(tmo[0])
    );
    xsim_run_ctrl #(.DERIVED_RESET_CYCLES(5), .DRAIN_TIMEOUT(4)) u_b (
        .CLK(CLK), .RST(RST), .finish_req(finish_req), .dut_idle(dut_idle),
        .rst_n_out(rn[1]), .derived_rst_release(dr[1]), .cycle_count(cc_b),
        .state(st[1]), .finish_now(fn[1]), .timed_out(tmo[1])
    );
    xsim_run_ctrl #(.RESET_CYCLES(0), .DERIVED_RESET_CYCLES(3), .DRAIN_TIMEOUT(0), .CNT_W(4)) u_c (
        .CLK(CLK), .RST(RST), .finish_req(finish_req), .dut_idle(dut_idle),
        .rst_n_out(rn[2]), .derived_rst_release(dr[2]), .cycle_count(cc_c),
        .state(st[2]), .finish_now(fn[2]), .timed_out(tmo[2])
    );

    function automatic logic [63:0] cc_of(input int i);
        return (i == 0) ? {32'd0, cc_a} : (i == 1) ? {32'd0, cc_b} : {60'd0, cc_c};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = 0;
        fr_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e[i] = -1;
            f[i] = -1;
            pend[i] = 1'b0;
            tflag[i] = 1'b0;
        end
    endtask

    task automatic check_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_rst_n[%0d]", i), 64'(rn[i]), 64'd0);
            chk($sformatf("rst_derived[%0d]", i), 64'(dr[i]), 64'd0);
            chk($sformatf("rst_count[%0d]", i), cc_of(i), 64'd0);
            chk($sformatf("rst_state[%0d]", i), 64'(st[i]), 64'd0);
            chk($sformatf("rst_finish[%0d]", i), 64'(fn[i]), 64'd0);
            chk($sformatf("rst_timed_out[%0d]", i), 64'(tmo[i]), 64'd0);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int es;
            longint ecc;
            ecc = (longint'(m) > mx[i]) ? mx[i] : longint'(m);
            es = (m < rc[i] + 1) ? 0 : (e[i] < 0 || m < e[i]) ? 1 : (f[i] < 0 || m < f[i]) ? 2 : (m == f[i]) ? 3 : 4;
            chk($sformatf("rst_n[%0d]@%0d", i, m), 64'(rn[i]), 64'(m >= rc[i] + 1));
            chk($sformatf("derived[%0d]@%0d", i, m), 64'(dr[i]), 64'(m >= drc[i] + 1));
            chk($sformatf("count[%0d]@%0d", i, m), cc_of(i), 64'(ecc));
            chk($sformatf("state[%0d]@%0d", i, m), 64'(st[i]), 64'(es));
            chk($sformatf("finish[%0d]@%0d", i, m), 64'(fn[i]), 64'(f[i] >= 0 && m == f[i]));
            chk($sformatf("timed_out[%0d]@%0d", i, m), 64'(tmo[i]), 64'(f[i] >= 0 && tflag[i]));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        m++;
        for (int i = 0; i < 3; i++) begin
            if (m <= rc[i] && finish_req) pend[i] = 1'b1;
            if (e[i] < 0 && m >= rc[i] + 2 && (pend[i] || fr_prev)) e[i] = m;
            else if (e[i] >= 0 && f[i] < 0 && m > e[i]) begin
                if (dut_idle) f[i] = m;
                else if (tov[i] != 0 && m == e[i] + tov[i]) begin
                    f[i] = m;
                    tflag[i] = 1'b1;
                end
            end
        end
        fr_prev = finish_req;
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check_reset();
        @(posedge CLK);
        #1;
        check_reset();
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        int unsigned p_req, p_idle;
        do_reset();
        run(25);
        do_reset();
        run(2);
        finish_req = 1'b1;
        run(20);
        dut_idle = 1'b1;
        run(3);
        finish_req = 1'b0;
        dut_idle = 1'b0;
        run(3);
        do_reset();
        run(2);
        finish_req = 1'b1;
        run(22);
        #2;
        RST = 1'b1;
        #1;
        check_reset();
        finish_req = 1'b0;
        do_reset();
        run(25);
        finish_req = 1'b1;
        step();
        finish_req = 1'b0;
        run(7);
        dut_idle = 1'b1;
        run(3);
        dut_idle = 1'b0;
        run(2);
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            p_req = $urandom_range(20, 3);
            p_idle = $urandom_range(12, 2);
            repeat (60) begin
                finish_req = ($urandom_range(p_req, 0) == 0);
                dut_idle = ($urandom_range(p_idle, 0) == 0);
                step();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
